// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC-to-Interfaz burst transmitter:
// FSM encoding, register indices and framing constants.
package rtc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StSend,
        StHold
    } state_e;

    localparam int unsigned N_DATOS       = 8;
    localparam logic [7:0]  BASE_ADDR_DEF = 8'h21;
    localparam logic [7:0]  HEADER_BYTE   = 8'h00;

    localparam int unsigned IDX_SEG    = 0;
    localparam int unsigned IDX_MIN    = 1;
    localparam int unsigned IDX_HORA   = 2;
    localparam int unsigned IDX_FECHA  = 3;
    localparam int unsigned IDX_MES    = 4;
    localparam int unsigned IDX_ANIO   = 5;
    localparam int unsigned IDX_DIA    = 6;
    localparam int unsigned IDX_SEMANA = 7;

endpackage

// File: rtl/rtc_secuencia_tx.sv
// Reads the eight RTC time registers on each tick and replays them to Interfaz
// as one framed burst (header, eight bytes, trailing hold on the last byte).
module rtc_secuencia_tx
    import rtc_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned RD_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    input  logic       rd_valid,
    output logic       inicioSecuencia,
    output logic [7:0] datoRTC,
    output logic       busy,
    output logic       rd_error
);

    state_e                  state_q, state_d;
    logic [2:0]              k_q, k_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [3:0]              pos_q, pos_d;
    logic [N_DATOS-1:0][7:0] shadow_q, shadow_d;
    logic [N_DATOS-1:0][7:0] send_q, send_d;
    logic                    rd_req_q, rd_req_d;
    logic                    rd_error_q, rd_error_d;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        shadow_d   = shadow_q;
        send_d     = send_q;
        rd_req_d   = 1'b0;
        rd_error_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d  = StReq;
                    k_d      = '0;
                    rd_req_d = 1'b1;
                end
            end
            StReq: begin
                state_d  = StWait;
                cnt_d    = '0;
                rd_req_d = 1'b1;
            end
            StWait: begin
                if (rd_valid) begin
                    shadow_d[k_q] = rd_data;
                    if (k_q == 3'(IDX_SEMANA)) begin
                        // Publish only once the whole set has arrived.
                        send_d             = shadow_q;
                        send_d[IDX_SEMANA] = rd_data;
                        state_d            = StSend;
                        pos_d              = '0;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = StReq;
                    end
                end else if (cnt_q == 8'(RD_TIMEOUT - 1)) begin
                    state_d    = StIdle;
                    rd_error_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                    rd_req_d = 1'b1;
                end
            end
            StSend: begin
                if (pos_q == 4'(N_DATOS)) begin
                    state_d = StHold;
                    pos_d   = '0;
                end else begin
                    pos_d = pos_q + 4'd1;
                end
            end
            StHold: begin
                if (pos_q == 4'(HOLD_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    pos_d = pos_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            k_q        <= '0;
            cnt_q      <= '0;
            pos_q      <= '0;
            shadow_q   <= '0;
            send_q     <= '0;
            rd_req_q   <= 1'b0;
            rd_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            shadow_q   <= shadow_d;
            send_q     <= send_d;
            rd_req_q   <= rd_req_d;
            rd_error_q <= rd_error_d;
        end
    end

    always_comb begin
        rd_req          = rd_req_q;
        rd_error        = rd_error_q;
        rd_addr         = rd_req_q ? (BASE_ADDR + {5'b0, k_q}) : 8'h00;
        busy            = (state_q != StIdle);
        inicioSecuencia = 1'b0;
        datoRTC         = 8'h00;
        unique case (state_q)
            StSend: begin
                inicioSecuencia = 1'b1;
                datoRTC = (pos_q == 4'd0) ? HEADER_BYTE : send_q[3'(pos_q - 4'd1)];
            end
            StHold: begin
                inicioSecuencia = 1'b1;
                datoRTC         = send_q[IDX_SEMANA];
            end
            default: begin
                inicioSecuencia = 1'b0;
                datoRTC         = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_secuencia_tx.sv
// Directed bench for rtc_secuencia_tx: an RTC responder answers reads after two
// clocks and a per-cycle monitor collects frame bytes and read addresses.
module tb_rtc_secuencia_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       rd_req, rd_valid, inicioSecuencia, busy, rd_error;
    logic [7:0] rd_addr, rd_data, datoRTC;

    logic       resp_valid = 1'b0;
    logic [7:0] resp_data = 8'h00;
    logic       stray_valid = 1'b0;
    logic [7:0] stray_data = 8'h00;
    logic [7:0] skip_addr = 8'hFF;
    int unsigned resp_cnt = 0;
    logic [7:0] resp_tab [8];

    logic [7:0] tab_a [8] = '{8'h24, 8'h04, 8'h03, 8'h23, 8'h12, 8'h17, 8'h05, 8'h04};
    logic [7:0] tab_b [8] = '{8'h59, 8'h58, 8'h57, 8'h56, 8'h55, 8'h54, 8'h53, 8'h52};
    logic [7:0] tab_c [8] = '{8'h01, 8'h02, 8'h10, 8'h31, 8'h11, 8'h99, 8'h07, 8'h02};
    logic [7:0] tab_d [8] = '{8'h45, 8'h30, 8'h19, 8'h28, 8'h02, 8'h25, 8'h06, 8'h08};

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] frame_q [$];
    logic [7:0] addr_q [$];
    int frames, addr_unstable, err_pulses, req24_cycles, fall_ini, err_at_fall;
    logic       prev_req = 1'b0;
    logic       prev_ini = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    always #5 clk = ~clk;

    assign rd_valid = resp_valid | stray_valid;
    assign rd_data  = stray_valid ? stray_data : resp_data;

    rtc_secuencia_tx dut (
        .clk             (clk),
        .reset           (reset),
        .tick            (tick),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .inicioSecuencia (inicioSecuencia),
        .datoRTC         (datoRTC),
        .busy            (busy),
        .rd_error        (rd_error)
    );

    // RTC model: answer each request two clocks after it is seen.
    always @(negedge clk) begin
        resp_valid = 1'b0;
        if (rd_req && rd_addr != skip_addr) begin
            resp_cnt++;
            if (resp_cnt == 2) begin
                resp_valid = 1'b1;
                resp_data  = resp_tab[3'(rd_addr - 8'h21)];
                resp_cnt   = 0;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    task automatic step();
        @(negedge clk);
        if (inicioSecuencia) frame_q.push_back(datoRTC);
        if (inicioSecuencia && !prev_ini) frames++;
        if (rd_req && !prev_req) addr_q.push_back(rd_addr);
        if (rd_req && prev_req && rd_addr != prev_addr) addr_unstable++;
        if (rd_error) err_pulses++;
        if (rd_req && rd_addr == 8'h24) req24_cycles++;
        if (prev_req && !rd_req && inicioSecuencia) fall_ini++;
        if (prev_req && !rd_req && rd_error) err_at_fall++;
        prev_req  = rd_req;
        prev_ini  = inicioSecuencia;
        prev_addr = rd_addr;
    endtask

    task automatic clear_mon();
        frame_q.delete();
        addr_q.delete();
        frames = 0; addr_unstable = 0; err_pulses = 0;
        req24_cycles = 0; fall_ini = 0; err_at_fall = 0;
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] t [8], input int i);
        if (i == 0) return 8'h00;
        if (i <= 8) return t[i-1];
        return t[7];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_checks++;
        if (rd_req !== 1'b0 || rd_addr !== 8'h00) begin
            n_fail++; $display("FAIL reset_rd: got req=%b addr=%h expected 0/00", rd_req, rd_addr);
        end
        n_checks++;
        if (inicioSecuencia !== 1'b0 || datoRTC !== 8'h00) begin
            n_fail++; $display("FAIL reset_frame: got ini=%b dato=%h expected 0/00",
                               inicioSecuencia, datoRTC);
        end
        n_checks++;
        if (busy !== 1'b0 || rd_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: got busy=%b err=%b expected 0/0", busy, rd_error);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_nominal();
        clear_mon();
        resp_tab = tab_a;
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_checks++;
        if (rd_req !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL nom_latency: got req=%b busy=%b expected 1/1", rd_req, busy);
        end
        for (int i = 0; i < 400 && busy; i++) step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL nom_timeout: busy still %b expected 0", busy);
        end
        n_checks++;
        if (frame_q.size() != 12 || frames != 1) begin
            n_fail++; $display("FAIL nom_frame_len: got %0d bytes %0d frames expected 12/1",
                               frame_q.size(), frames);
        end
        for (int i = 0; i < 12 && i < frame_q.size(); i++) begin
            n_checks++;
            if (frame_q[i] !== exp_byte(tab_a, i)) begin
                n_fail++; $display("FAIL nom_byte%0d: got %h expected %h", i, frame_q[i],
                                   exp_byte(tab_a, i));
            end
        end
        n_checks++;
        if (addr_q.size() != 8) begin
            n_fail++; $display("FAIL addr_count: got %0d expected 8", addr_q.size());
        end
        for (int i = 0; i < 8 && i < addr_q.size(); i++) begin
            n_checks++;
            if (addr_q[i] !== 8'(8'h21 + i)) begin
                n_fail++; $display("FAIL addr%0d: got %h expected %h", i, addr_q[i], 8'(8'h21 + i));
            end
        end
        n_checks++;
        if (addr_unstable != 0) begin
            n_fail++; $display("FAIL addr_stable: got %0d changes expected 0", addr_unstable);
        end
        n_checks++;
        if (fall_ini != 1 || rd_req !== 1'b0) begin
            n_fail++; $display("FAIL last_valid_to_c0: got %0d req=%b expected 1/0", fall_ini, rd_req);
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        resp_tab  = tab_b;
        skip_addr = 8'h24;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 1000 && busy; i++) step();
        repeat (3) step();
        n_checks++;
        if (req24_cycles != 255) begin
            n_fail++; $display("FAIL to_wait_len: got %0d expected 255", req24_cycles);
        end
        n_checks++;
        if (err_pulses != 1 || err_at_fall != 1) begin
            n_fail++; $display("FAIL to_err_pulse: got %0d pulses %0d aligned expected 1/1",
                               err_pulses, err_at_fall);
        end
        n_checks++;
        if (frames != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL to_no_frame: got %0d frames busy=%b expected 0/0", frames, busy);
        end
        skip_addr = 8'hFF;
        clear_mon();
        resp_tab = tab_c;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 400 && busy; i++) step();
        n_checks++;
        if (frame_q.size() != 12 || err_pulses != 0) begin
            n_fail++; $display("FAIL to_recover_len: got %0d bytes %0d errs expected 12/0",
                               frame_q.size(), err_pulses);
        end
        for (int i = 0; i < 12 && i < frame_q.size(); i++) begin
            n_checks++;
            if (frame_q[i] !== exp_byte(tab_c, i)) begin
                n_fail++; $display("FAIL to_byte%0d: got %h expected %h", i, frame_q[i],
                                   exp_byte(tab_c, i));
            end
        end
    endtask

    task automatic test_busy_ignore();
        clear_mon();
        resp_tab = tab_a;
        tick = 1'b1;
        step();
        for (int i = 0; i < 400 && busy; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
        repeat (3) step();
        n_checks++;
        if (frames != 1 || frame_q.size() != 12 || addr_q.size() != 8) begin
            n_fail++; $display("FAIL busy_single: got %0d frames %0d bytes %0d reads expected 1/12/8",
                               frames, frame_q.size(), addr_q.size());
        end
        n_checks++;
        if (busy !== 1'b0 || rd_req !== 1'b0) begin
            n_fail++; $display("FAIL busy_no_queue: got busy=%b req=%b expected 0/0", busy, rd_req);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || rd_req !== 1'b1) begin
            n_fail++; $display("FAIL busy_restart: got busy=%b req=%b expected 1/1", busy, rd_req);
        end
        for (int i = 0; i < 400 && busy; i++) step();
        n_checks++;
        if (frames != 2) begin
            n_fail++; $display("FAIL busy_second: got %0d frames expected 2", frames);
        end
    endtask

    task automatic test_stray_valid();
        clear_mon();
        resp_tab    = tab_d;
        stray_data  = 8'hEE;
        stray_valid = 1'b1;
        repeat (2) step();
        stray_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || rd_req !== 1'b0) begin
            n_fail++; $display("FAIL stray_idle: got busy=%b req=%b expected 0/0", busy, rd_req);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 400 && busy; i++) begin
            if (inicioSecuencia) stray_valid = 1'b1;
            step();
        end
        stray_valid = 1'b0;
        n_checks++;
        if (frame_q.size() != 12) begin
            n_fail++; $display("FAIL stray_len: got %0d expected 12", frame_q.size());
        end
        for (int i = 0; i < 12 && i < frame_q.size(); i++) begin
            n_checks++;
            if (frame_q[i] !== exp_byte(tab_d, i)) begin
                n_fail++; $display("FAIL stray_byte%0d: got %h expected %h", i, frame_q[i],
                                   exp_byte(tab_d, i));
            end
        end
    endtask

    task automatic test_reset_mid_send();
        clear_mon();
        resp_tab = tab_a;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 400 && !inicioSecuencia; i++) step();
        n_checks++;
        if (inicioSecuencia !== 1'b1) begin
            n_fail++; $display("FAIL rst_c0: got ini=%b expected 1", inicioSecuencia);
        end
        repeat (4) step();
        n_checks++;
        if (datoRTC !== tab_a[3]) begin
            n_fail++; $display("FAIL rst_c4_byte: got %h expected %h", datoRTC, tab_a[3]);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (inicioSecuencia !== 1'b0 || datoRTC !== 8'h00 || busy !== 1'b0 || rd_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_abort: got ini=%b dato=%h busy=%b req=%b expected 0/00/0/0",
                               inicioSecuencia, datoRTC, busy, rd_req);
        end
        reset = 1'b0;
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b0 || inicioSecuencia !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_resume: got busy=%b ini=%b expected 0/0",
                               busy, inicioSecuencia);
        end
    endtask

    initial begin
        resp_tab = tab_a;
        clear_mon();
        test_reset();
        test_nominal();
        test_timeout();
        test_busy_ignore();
        test_stray_valid();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
